// File: rtl/pingpong_if.sv
// Key-pulse inputs and display outputs of the ping-pong game controller.
// master = key/display side, slave = game controller.
interface pingpong_if #(
  parameter int LED_NUM = 8
);
  logic               key1_pulse_n;
  logic               key2_pulse_n;
  logic [LED_NUM-1:0] led;
  logic [3:0]         score1;
  logic [3:0]         score2;
  logic               game_over;
  logic               winner;

  modport master (
    output key1_pulse_n, key2_pulse_n,
    input  led, score1, score2, game_over, winner
  );

  modport slave (
    input  key1_pulse_n, key2_pulse_n,
    output led, score1, score2, game_over, winner
  );
endinterface

// File: rtl/pingpong_ctrl.sv
// Ping-pong rally controller: serve, ball travel, hit windows, fouls, scoring
// and game-over display. All outputs come straight from registers.
module pingpong_ctrl #(
  parameter int LED_NUM     = 8,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  pingpong_if.slave  bus
);

  localparam int POS_W = $clog2(LED_NUM);
  localparam int TMR_W = $clog2(2 * STEP_CYCLES);

  localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(LED_NUM - 1);
  localparam logic [POS_W-1:0]   NEAR_P1    = POS_W'(LED_NUM - 2);
  localparam logic [TMR_W-1:0]   STEP_LAST  = TMR_W'(STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0]   POINT_LAST = TMR_W'(2 * STEP_CYCLES - 1);
  localparam logic [3:0]         WIN4       = 4'(WIN_SCORE);
  localparam logic [LED_NUM-1:0] LED_ONE    = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] LED_RESET  = {1'b1, {(LED_NUM-1){1'b0}}};
  localparam logic [LED_NUM-1:0] LED_UPPER  = {{(LED_NUM/2){1'b1}}, {(LED_NUM/2){1'b0}}};
  localparam logic [LED_NUM-1:0] LED_LOWER  = ~LED_UPPER;

  typedef enum logic [2:0] {
    SERVE1,
    SERVE2,
    TO_P2,
    TO_P1,
    POINT,
    OVER
  } state_t;

  state_t             r_state;
  logic [POS_W-1:0]   r_pos;
  logic [TMR_W-1:0]   r_tmr;
  logic [3:0]         r_score1;
  logic [3:0]         r_score2;
  logic               r_winner;
  logic               r_game_over;
  logic               r_pt_p1;      // point in progress was credited to player 1
  logic [LED_NUM-1:0] r_led;

  state_t             w_state_nxt;
  logic [POS_W-1:0]   w_pos_nxt;
  logic [TMR_W-1:0]   w_tmr_nxt;
  logic [3:0]         w_score1_nxt;
  logic [3:0]         w_score2_nxt;
  logic               w_winner_nxt;
  logic               w_pt_p1_nxt;
  logic [LED_NUM-1:0] w_led_nxt;
  logic               w_key1;
  logic               w_key2;
  logic               w_expire;

  assign w_key1   = ~bus.key1_pulse_n;
  assign w_key2   = ~bus.key2_pulse_n;
  assign w_expire = (r_tmr == STEP_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_tmr_nxt    = r_tmr;
    w_score1_nxt = r_score1;
    w_score2_nxt = r_score2;
    w_winner_nxt = r_winner;
    w_pt_p1_nxt  = r_pt_p1;

    unique case (r_state)
      SERVE1: begin
        if (w_key1) begin
          w_state_nxt = TO_P2;
          w_pos_nxt   = NEAR_P1;
          w_tmr_nxt   = '0;
        end
      end

      SERVE2: begin
        if (w_key2) begin
          w_state_nxt = TO_P1;
          w_pos_nxt   = POS_W'(1);
          w_tmr_nxt   = '0;
        end
      end

      // A hit on the expiry cycle wins over the step, so keys are tested first.
      TO_P2: begin
        if (w_key2) begin
          w_tmr_nxt = '0;
          if (r_pos == '0) begin
            w_state_nxt = TO_P1;
            w_pos_nxt   = POS_W'(1);
          end else begin
            w_state_nxt  = POINT;
            w_score1_nxt = r_score1 + 4'd1;
            w_pt_p1_nxt  = 1'b1;
          end
        end else if (w_expire) begin
          w_tmr_nxt = '0;
          if (r_pos != '0) begin
            w_pos_nxt = r_pos - POS_W'(1);
          end else begin
            w_state_nxt  = POINT;
            w_score1_nxt = r_score1 + 4'd1;
            w_pt_p1_nxt  = 1'b1;
          end
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end

      TO_P1: begin
        if (w_key1) begin
          w_tmr_nxt = '0;
          if (r_pos == LAST_POS) begin
            w_state_nxt = TO_P2;
            w_pos_nxt   = NEAR_P1;
          end else begin
            w_state_nxt  = POINT;
            w_score2_nxt = r_score2 + 4'd1;
            w_pt_p1_nxt  = 1'b0;
          end
        end else if (w_expire) begin
          w_tmr_nxt = '0;
          if (r_pos != LAST_POS) begin
            w_pos_nxt = r_pos + POS_W'(1);
          end else begin
            w_state_nxt  = POINT;
            w_score2_nxt = r_score2 + 4'd1;
            w_pt_p1_nxt  = 1'b0;
          end
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end

      // The timer doubles as the point-display counter; the conceder serves next.
      POINT: begin
        if (r_tmr == POINT_LAST) begin
          w_tmr_nxt = '0;
          if (r_pt_p1) begin
            if (r_score1 == WIN4) begin
              w_state_nxt  = OVER;
              w_winner_nxt = 1'b0;
            end else begin
              w_state_nxt = SERVE2;
              w_pos_nxt   = '0;
            end
          end else begin
            if (r_score2 == WIN4) begin
              w_state_nxt  = OVER;
              w_winner_nxt = 1'b1;
            end else begin
              w_state_nxt = SERVE1;
              w_pos_nxt   = LAST_POS;
            end
          end
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end

      OVER: begin
        if (w_key1 || w_key2) begin
          w_state_nxt  = SERVE1;
          w_pos_nxt    = LAST_POS;
          w_tmr_nxt    = '0;
          w_score1_nxt = '0;
          w_score2_nxt = '0;
          w_winner_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = SERVE1;
        w_pos_nxt   = LAST_POS;
        w_tmr_nxt   = '0;
      end
    endcase

    // The LED row is decoded from the next state so it changes on the same edge.
    if (w_state_nxt == POINT) begin
      w_led_nxt = '1;
    end else if (w_state_nxt == OVER) begin
      w_led_nxt = w_winner_nxt ? LED_LOWER : LED_UPPER;
    end else begin
      w_led_nxt = LED_ONE << w_pos_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SERVE1;
      r_pos       <= LAST_POS;
      r_tmr       <= '0;
      r_score1    <= '0;
      r_score2    <= '0;
      r_winner    <= 1'b0;
      r_game_over <= 1'b0;
      r_pt_p1     <= 1'b0;
      r_led       <= LED_RESET;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_tmr       <= w_tmr_nxt;
      r_score1    <= w_score1_nxt;
      r_score2    <= w_score2_nxt;
      r_winner    <= w_winner_nxt;
      r_game_over <= (w_state_nxt == OVER);
      r_pt_p1     <= w_pt_p1_nxt;
      r_led       <= w_led_nxt;
    end
  end

  assign bus.led       = r_led;
  assign bus.score1    = r_score1;
  assign bus.score2    = r_score2;
  assign bus.game_over = r_game_over;
  assign bus.winner    = r_winner;

  a_score_bound: assert property (@(posedge clk) disable iff (!rst)
    (r_score1 <= WIN4) && (r_score2 <= WIN4));
  a_pos_range: assert property (@(posedge clk) disable iff (!rst)
    r_pos <= LAST_POS);
  a_over_flag: assert property (@(posedge clk) disable iff (!rst)
    r_game_over == (r_state == OVER));

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Scenario bench for pingpong_ctrl: expected outputs are queued when a step is
// driven and popped/compared once the step's cycles have elapsed.
module tb_pingpong_ctrl;

  localparam int LED_NUM = 8;
  localparam int STEP    = 4;
  localparam int WIN     = 3;

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       go;
    logic       win;
  } out_t;

  typedef struct {
    int   n;
    bit   k1;
    bit   k2;
    out_t exp;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pingpong_if #(.LED_NUM(LED_NUM)) bus ();

  pingpong_ctrl #(
    .LED_NUM    (LED_NUM),
    .STEP_CYCLES(STEP),
    .WIN_SCORE  (WIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  out_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic out_t observed();
    return {bus.led, bus.score1, bus.score2, bus.game_over, bus.winner};
  endfunction

  function automatic step_t mk(int n, bit k1, bit k2, logic [7:0] led,
                               int s1, int s2, bit go = 1'b0, bit win = 1'b0);
    step_t s;
    s.n   = n;
    s.k1  = k1;
    s.k2  = k2;
    s.exp = {led, 4'(s1), 4'(s2), go, win};
    return s;
  endfunction

  // Drive keys for the first cycle of the step, queue the expectation, then
  // run the remaining cycles. Always entered and left on a falling edge.
  task automatic run_step(string name, step_t s);
    bus.key1_pulse_n = ~s.k1;
    bus.key2_pulse_n = ~s.k2;
    exp_q.push_back(s.exp);
    name_q.push_back(name);
    @(negedge clk);
    bus.key1_pulse_n = 1'b1;
    bus.key2_pulse_n = 1'b1;
    repeat (s.n - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    step_t st[$];
    out_t  got, want;
    string nm;
    repeat (3) @(negedge clk);
    exp_q.push_back({8'h80, 4'd0, 4'd0, 1'b0, 1'b0});
    name_q.push_back("reset_held");
    got = observed(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
    rst = 1'b1;
    st.push_back(mk(1, 0, 0, 8'h80, 0, 0));
    st.push_back(mk(1, 0, 1, 8'h80, 0, 0));
    st.push_back(mk(2, 0, 0, 8'h80, 0, 0));
    foreach (st[i]) begin
      run_step("reset", st[i]);
      got = observed(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s[%0d]: got led=%b s1=%0d s2=%0d go=%b win=%b, expected led=%b s1=%0d s2=%0d go=%b win=%b",
                 nm, i, got.led, got.s1, got.s2, got.go, got.win,
                 want.led, want.s1, want.s2, want.go, want.win);
      end
    end
  endtask

  task automatic test_serve_miss();
    step_t st[$];
    out_t  got, want;
    string nm;
    st.push_back(mk(1,  1, 0, 8'h40, 0, 0));
    st.push_back(mk(3,  0, 0, 8'h40, 0, 0));
    st.push_back(mk(1,  0, 0, 8'h20, 0, 0));
    st.push_back(mk(20, 0, 0, 8'h01, 0, 0));
    st.push_back(mk(3,  0, 0, 8'h01, 0, 0));
    st.push_back(mk(1,  0, 0, 8'hFF, 1, 0));
    st.push_back(mk(7,  0, 0, 8'hFF, 1, 0));
    st.push_back(mk(1,  0, 0, 8'h01, 1, 0));
    foreach (st[i]) begin
      run_step("serve_miss", st[i]);
      got = observed(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s[%0d]: got led=%b s1=%0d s2=%0d go=%b win=%b, expected led=%b s1=%0d s2=%0d go=%b win=%b",
                 nm, i, got.led, got.s1, got.s2, got.go, got.win,
                 want.led, want.s1, want.s2, want.go, want.win);
      end
    end
  endtask

  task automatic test_return();
    step_t st[$];
    out_t  got, want;
    string nm;
    st.push_back(mk(1,  0, 1, 8'h02, 1, 0));
    st.push_back(mk(4,  0, 0, 8'h04, 1, 0));
    st.push_back(mk(20, 0, 0, 8'h80, 1, 0));
    st.push_back(mk(2,  0, 0, 8'h80, 1, 0));
    st.push_back(mk(1,  1, 0, 8'h40, 1, 0));
    st.push_back(mk(24, 0, 0, 8'h01, 1, 0));
    st.push_back(mk(1,  0, 1, 8'h02, 1, 0));
    st.push_back(mk(24, 0, 0, 8'h80, 1, 0));
    st.push_back(mk(3,  0, 0, 8'h80, 1, 0));
    st.push_back(mk(1,  1, 0, 8'h40, 1, 0));
    st.push_back(mk(24, 0, 0, 8'h01, 1, 0));
    st.push_back(mk(3,  0, 0, 8'h01, 1, 0));
    st.push_back(mk(1,  0, 1, 8'h02, 1, 0));
    foreach (st[i]) begin
      run_step("return", st[i]);
      got = observed(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s[%0d]: got led=%b s1=%0d s2=%0d go=%b win=%b, expected led=%b s1=%0d s2=%0d go=%b win=%b",
                 nm, i, got.led, got.s1, got.s2, got.go, got.win,
                 want.led, want.s1, want.s2, want.go, want.win);
      end
    end
  endtask

  task automatic test_foul();
    step_t st[$];
    out_t  got, want;
    string nm;
    st.push_back(mk(24, 0, 0, 8'h80, 1, 0));
    st.push_back(mk(1,  1, 0, 8'h40, 1, 0));
    st.push_back(mk(1,  1, 0, 8'h40, 1, 0));
    st.push_back(mk(7,  0, 0, 8'h10, 1, 0));
    st.push_back(mk(4,  0, 0, 8'h08, 1, 0));
    st.push_back(mk(1,  0, 1, 8'hFF, 2, 0));
    st.push_back(mk(7,  0, 0, 8'hFF, 2, 0));
    st.push_back(mk(1,  0, 0, 8'h01, 2, 0));
    st.push_back(mk(1,  1, 0, 8'h01, 2, 0));
    foreach (st[i]) begin
      run_step("foul", st[i]);
      got = observed(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s[%0d]: got led=%b s1=%0d s2=%0d go=%b win=%b, expected led=%b s1=%0d s2=%0d go=%b win=%b",
                 nm, i, got.led, got.s1, got.s2, got.go, got.win,
                 want.led, want.s1, want.s2, want.go, want.win);
      end
    end
  endtask

  task automatic test_game_end();
    step_t st[$];
    out_t  got, want;
    string nm;
    st.push_back(mk(1,  0, 1, 8'h02, 2, 0));
    st.push_back(mk(1,  0, 1, 8'h02, 2, 0));
    st.push_back(mk(23, 0, 0, 8'h80, 2, 0));
    st.push_back(mk(1,  1, 0, 8'h40, 2, 0));
    st.push_back(mk(1,  0, 1, 8'hFF, 3, 0));
    st.push_back(mk(7,  0, 0, 8'hFF, 3, 0));
    st.push_back(mk(1,  0, 0, 8'hF0, 3, 0, 1'b1, 1'b0));
    st.push_back(mk(3,  0, 0, 8'hF0, 3, 0, 1'b1, 1'b0));
    st.push_back(mk(1,  0, 1, 8'h80, 0, 0));
    foreach (st[i]) begin
      run_step("game_end", st[i]);
      got = observed(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s[%0d]: got led=%b s1=%0d s2=%0d go=%b win=%b, expected led=%b s1=%0d s2=%0d go=%b win=%b",
                 nm, i, got.led, got.s1, got.s2, got.go, got.win,
                 want.led, want.s1, want.s2, want.go, want.win);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t st[$];
    out_t  got, want;
    string nm;
    st.push_back(mk(1, 1, 0, 8'h40, 0, 0));
    st.push_back(mk(1, 0, 1, 8'hFF, 1, 0));
    st.push_back(mk(8, 0, 0, 8'h01, 1, 0));
    st.push_back(mk(1, 0, 1, 8'h02, 1, 0));
    st.push_back(mk(1, 1, 0, 8'hFF, 1, 1));
    st.push_back(mk(8, 0, 0, 8'h80, 1, 1));
    st.push_back(mk(1, 1, 0, 8'h40, 1, 1));
    st.push_back(mk(1, 0, 1, 8'hFF, 2, 1));
    st.push_back(mk(8, 0, 0, 8'h01, 2, 1));
    st.push_back(mk(1, 0, 1, 8'h02, 2, 1));
    st.push_back(mk(1, 1, 0, 8'hFF, 2, 2));
    st.push_back(mk(8, 0, 0, 8'h80, 2, 2));
    st.push_back(mk(1, 1, 0, 8'h40, 2, 2));
    st.push_back(mk(8, 0, 0, 8'h10, 2, 2));
    foreach (st[i]) begin
      run_step("rally_setup", st[i]);
      got = observed(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s[%0d]: got led=%b s1=%0d s2=%0d go=%b win=%b, expected led=%b s1=%0d s2=%0d go=%b win=%b",
                 nm, i, got.led, got.s1, got.s2, got.go, got.win,
                 want.led, want.s1, want.s2, want.go, want.win);
      end
    end
    // Phase 0: assert mid-cycle, phase 1: key during reset, phase 2: release + serve.
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0: begin
          #2 rst = 1'b0;
          exp_q.push_back({8'h80, 4'd0, 4'd0, 1'b0, 1'b0});
          name_q.push_back("reset_async");
          #1;
        end
        1: begin
          @(negedge clk) bus.key1_pulse_n = 1'b0;
          exp_q.push_back({8'h80, 4'd0, 4'd0, 1'b0, 1'b0});
          name_q.push_back("reset_hold");
          @(negedge clk) bus.key1_pulse_n = 1'b1;
          @(negedge clk);
        end
        default: begin
          rst = 1'b1;
          bus.key1_pulse_n = 1'b0;
          exp_q.push_back({8'h40, 4'd0, 4'd0, 1'b0, 1'b0});
          name_q.push_back("first_serve");
          @(negedge clk);
          bus.key1_pulse_n = 1'b1;
        end
      endcase
      got = observed(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s: got led=%b s1=%0d s2=%0d go=%b win=%b, expected led=%b s1=%0d s2=%0d go=%b win=%b",
                 nm, got.led, got.s1, got.s2, got.go, got.win,
                 want.led, want.s1, want.s2, want.go, want.win);
      end
    end
  endtask

  initial begin
    bus.key1_pulse_n = 1'b1;
    bus.key2_pulse_n = 1'b1;
    test_reset();
    test_serve_miss();
    test_return();
    test_foul();
    test_game_end();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", n_vec);
    $fatal(1, "time limit");
  end

endmodule
